paramest_dense_accum: RTL and testbench

- Downstream consumer of the dense-layer product multiplier (signed 16-bit weight × unsigned 15-bit activation -> signed 31-bit product) in the ParamEst NN datapath.
- Accumulates N_IN products per output neuron and adds a per-neuron bias.
- Requantizes the sum (round, shift, optional ReLU, saturate) to OUT_W and emits one result per neuron over a valid/ready handshake to the next layer.

---
 rtl/paramest_nn_pkg.sv | 42 ++++
 rtl/paramest_requant.sv | 24 ++
 rtl/paramest_dense_accum.sv | 114 +++++++++++
 tb/tb_paramest_dense_accum.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/paramest_nn_pkg.sv
// paramest_nn_pkg: shared widths, FSM state type and the round/shift/ReLU/saturate helper
// used by the ParamEst NN layer datapaths.
package paramest_nn_pkg;

    localparam int PROD_W_DEF = 31;
    localparam int BIAS_W_DEF = 24;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_QUANT,
        S_OUTPUT
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_round_t;

    // Values are carried at 64 bits so one function serves every layer width.
    // ReLU is applied before the clamp, so zeroing a negative never counts as saturation.
    function automatic sat_round_t sat_round(
        input logic signed [63:0] v,
        input int                 shift,
        input int                 out_w,
        input logic               relu
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_round_t         res;
        r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        if (relu && r < 0) r = '0;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        res.sat = (r > hi) || (r < lo);
        res.val = (r > hi) ? hi : (r < lo) ? lo : r;
        return res;
    endfunction

endpackage

// File: rtl/paramest_requant.sv
// paramest_requant: combinational requantizer, ACC_W accumulator -> OUT_W result plus
// saturation bit.
module paramest_requant #(
    parameter int ACC_W = 37,
    parameter int SHIFT = 10,
    parameter int OUT_W = 16,
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);
    import paramest_nn_pkg::*;

    sat_round_t w_res;
    logic       w_unused;

    assign w_res    = sat_round({{(64-ACC_W){i_acc[ACC_W-1]}}, i_acc}, SHIFT, OUT_W, RELU != 0);
    assign o_data   = w_res.val[OUT_W-1:0];
    assign o_sat    = w_res.sat;
    // After the clamp the upper bits are pure sign extension.
    assign w_unused = ^w_res.val[63:OUT_W];

endmodule

// File: rtl/paramest_dense_accum.sv
// paramest_dense_accum: accumulates N_IN signed products plus bias per neuron, then
// requantizes and hands one result per neuron downstream over valid/ready.
module paramest_dense_accum
    import paramest_nn_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int N_IN   = 16,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int SHIFT  = 10,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int RELU   = 1,
    localparam int ACC_W = PROD_W + $clog2(N_IN) + 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [BIAS_W-1:0] bias_data,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag,
    output logic                     busy
);
    localparam int CNT_W = $clog2(N_IN + 1);

    state_t                  r_state;
    state_t                  w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_sat;
    logic signed [ACC_W-1:0] w_prod_x;
    logic signed [ACC_W-1:0] w_bias_x;
    logic signed [OUT_W-1:0] w_q;
    logic                    w_q_sat;
    logic                    w_beat;
    logic                    w_last;

    assign w_prod_x = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    assign w_bias_x = {{(ACC_W-BIAS_W){bias_data[BIAS_W-1]}}, bias_data};

    // Gated by reset so nothing is offered upstream while reset is held.
    assign prod_ready = ap_rst_n && (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_beat     = prod_valid && prod_ready;
    assign w_last     = r_cnt == CNT_W'(N_IN - 1);

    assign out_valid  = r_state == S_OUTPUT;
    assign out_data   = r_out_data;
    assign sat_flag   = r_sat;
    assign busy       = r_state != S_IDLE;

    paramest_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W),
        .RELU  (RELU)
    ) u_requant (
        .i_acc  (r_acc),
        .o_data (w_q),
        .o_sat  (w_q_sat)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_beat ? S_ACCUM : S_IDLE;
            S_ACCUM:  w_next = (w_beat && w_last) ? S_QUANT : S_ACCUM;
            S_QUANT:  w_next = S_OUTPUT;
            S_OUTPUT: w_next = out_ready ? S_IDLE : S_OUTPUT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sat   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_acc <= w_bias_x + w_prod_x;
                        r_cnt <= CNT_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_prod_x;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_QUANT: begin
                    r_out_data <= w_q;
                    r_sat      <= w_q_sat;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_paramest_dense_accum.sv
// tb_paramest_dense_accum: table-driven bench for the dense accumulator, run with ReLU on
// and off side by side, plus stall, backpressure and mid-neuron reset sequences.
module tb_paramest_dense_accum;
    localparam int PROD_W = 31;
    localparam int BIAS_W = 24;
    localparam int OUT_W  = 16;
    localparam int N_IN   = 4;
    localparam int SHIFT  = 4;
    localparam int JUNK   = 'h123456;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n = 1'b0;
    logic signed [PROD_W-1:0] prod_data = '0;
    logic                     prod_valid = 1'b0;
    logic signed [BIAS_W-1:0] bias_data = '0;
    logic                     out_ready = 1'b1;

    logic                     prod_ready1, out_valid1, sat_flag1, busy1;
    logic signed [OUT_W-1:0]  out_data1;
    logic                     prod_ready0, out_valid0, sat_flag0, busy0;
    logic signed [OUT_W-1:0]  out_data0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 ap_clk = ~ap_clk;

    paramest_dense_accum #(.PROD_W(PROD_W), .N_IN(N_IN), .BIAS_W(BIAS_W), .SHIFT(SHIFT),
                           .OUT_W(OUT_W), .RELU(1)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready1), .bias_data(bias_data), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .sat_flag(sat_flag1), .busy(busy1)
    );

    paramest_dense_accum #(.PROD_W(PROD_W), .N_IN(N_IN), .BIAS_W(BIAS_W), .SHIFT(SHIFT),
                           .OUT_W(OUT_W), .RELU(0)) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready0), .bias_data(bias_data), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .sat_flag(sat_flag0), .busy(busy0)
    );

    typedef struct {
        int p0, p1, p2, p3;
        int bias;
        int e1, s1;
        int e0, s0;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int p, input int b);
        @(negedge ap_clk);
        prod_valid = 1'b1;
        prod_data  = PROD_W'(p);
        bias_data  = BIAS_W'(b);
    endtask

    task automatic run_vec(input vec_t v, input bit gaps, input string tag);
        int p[4];
        p = '{v.p0, v.p1, v.p2, v.p3};
        for (int i = 0; i < 4; i++) begin
            send(p[i], i == 0 ? v.bias : JUNK);
            if (gaps && i < 3) begin
                @(negedge ap_clk);
                prod_valid = 1'b0;
                chk({tag, "_gap_busy_a"}, busy1, 1);
                @(negedge ap_clk);
                chk({tag, "_gap_busy_b"}, busy1, 1);
            end
        end
        @(negedge ap_clk);
        prod_valid = 1'b0;
        chk({tag, "_quant_valid"}, out_valid1, 0);
        @(negedge ap_clk);
        chk({tag, "_valid"}, out_valid1, 1);
        chk({tag, "_data_relu"}, int'(out_data1), v.e1);
        chk({tag, "_sat_relu"}, sat_flag1, v.s1);
        chk({tag, "_data_norelu"}, int'(out_data0), v.e0);
        chk({tag, "_sat_norelu"}, sat_flag0, v.s0);
        chk({tag, "_busy"}, busy1, 1);
        @(negedge ap_clk);
        chk({tag, "_valid_after"}, out_valid1, 0);
        chk({tag, "_sat_pulse"}, sat_flag0, 0);
        chk({tag, "_busy_after"}, busy1, 0);
    endtask

    initial begin
        vt[0]  = '{16, 32, 48, 64, 8, 11, 0, 11, 0};
        vt[1]  = '{-100, -100, -100, -100, 0, 0, 0, -25, 0};
        vt[2]  = '{1073741823, 1073741823, 1073741823, 1073741823, 0, 32767, 1, 32767, 1};
        vt[3]  = '{-1073741824, -1073741824, -1073741824, -1073741824, 0, 0, 0, -32768, 1};
        vt[4]  = '{131068, 131068, 131068, 131068, 0, 32767, 0, 32767, 0};
        vt[5]  = '{131070, 131070, 131070, 131070, 0, 32767, 1, 32767, 1};
        vt[6]  = '{-131072, -131072, -131072, -131072, 0, 0, 0, -32768, 0};
        vt[7]  = '{-131074, -131074, -131074, -131074, -1, 0, 0, -32768, 1};
        vt[8]  = '{-9, 0, 0, 0, 0, 0, 0, -1, 0};
        vt[9]  = '{0, 0, 0, 0, -8388608, 0, 0, -32768, 1};
        vt[10] = '{1, 2, 2, 3, 0, 1, 0, 1, 0};
        vt[11] = '{1, 2, 2, 2, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0, -8, 0, 0, 0, 0, 0};

        @(negedge ap_clk);
        chk("rst_valid", out_valid1, 0);
        chk("rst_data", int'(out_data1), 0);
        chk("rst_sat", sat_flag1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ready", prod_ready1, 0);
        chk("rst_ready_norelu", prod_ready0, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

        run_vec(vt[0], 1'b1, "gaps");

        // Backpressure: result must hold while a new beat waits upstream.
        out_ready = 1'b0;
        send(16, 8);
        send(32, JUNK);
        send(48, JUNK);
        send(64, JUNK);
        @(negedge ap_clk);
        prod_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            prod_valid = 1'b1;
            prod_data  = PROD_W'(1000);
            bias_data  = '0;
            chk($sformatf("bp%0d_valid", k), out_valid1, 1);
            chk($sformatf("bp%0d_data", k), int'(out_data1), 11);
            chk($sformatf("bp%0d_ready", k), prod_ready1, 0);
            if (k > 0) chk($sformatf("bp%0d_sat", k), sat_flag1, 0);
        end
        out_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_release_valid", out_valid1, 0);
        chk("bp_release_ready", prod_ready1, 1);
        chk("bp_release_busy", busy1, 0);
        send(0, JUNK);
        send(0, JUNK);
        send(0, JUNK);
        @(negedge ap_clk);
        prod_valid = 1'b0;
        @(negedge ap_clk);
        chk("bp_next_valid", out_valid1, 1);
        chk("bp_next_data", int'(out_data1), 63);
        chk("bp_next_data_norelu", int'(out_data0), 63);
        @(negedge ap_clk);

        // Reset mid-neuron discards the partial sum.
        send(1000, 0);
        send(1000, JUNK);
        @(negedge ap_clk);
        prod_valid = 1'b0;
        ap_rst_n   = 1'b0;
        #1;
        chk("midrst_valid", out_valid1, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_ready", prod_ready1, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_vec(vt[0], 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
